and_gate_sync: RTL and testbench



---
 rtl/and_gate_sync.sv | 72 +++++++
 tb/tb_and_gate_sync.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/and_gate_sync.sv
// Bitwise two-input AND with a combinational result, a registered copy,
// sticky {A[0],B[0]} coverage flags and a saturating non-zero-result counter.
module and_gate_sync #(
    parameter int WIDTH   = 1,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic [WIDTH-1:0]   Y,
    output logic [WIDTH-1:0]   Y_q,
    output logic [3:0]         seen,
    output logic               all_seen,
    output logic [COUNT_W-1:0] hi_cnt
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

    logic [WIDTH-1:0]   andVal;
    logic [1:0]         seenIdx;
    logic [WIDTH-1:0]   yCap_d,  yCap_q;
    logic [3:0]         seen_d,  seen_q;
    logic [COUNT_W-1:0] hiCnt_d, hiCnt_q;

    assign andVal  = A & B;
    assign seenIdx = {A[0], B[0]};

    // clr outranks both the coverage set and the counter increment, but
    // leaves the captured result alone.
    always_comb begin
        yCap_d  = yCap_q;
        seen_d  = seen_q;
        hiCnt_d = hiCnt_q;

        if (en) begin
            yCap_d = andVal;
        end

        if (clr) begin
            seen_d  = '0;
            hiCnt_d = '0;
        end else begin
            seen_d = seen_q | (4'b0001 << seenIdx);
            if (en && (|andVal) && (hiCnt_q != CNT_MAX)) begin
                hiCnt_d = hiCnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            yCap_q  <= '0;
            seen_q  <= '0;
            hiCnt_q <= '0;
        end else begin
            yCap_q  <= yCap_d;
            seen_q  <= seen_d;
            hiCnt_q <= hiCnt_d;
        end
    end

    assign Y        = andVal;
    assign Y_q      = yCap_q;
    assign seen     = seen_q;
    assign all_seen = &seen_q;
    assign hi_cnt   = hiCnt_q;

endmodule

// File: tb/tb_and_gate_sync.sv
// Self-checking bench for and_gate_sync: a narrow instance (WIDTH=1, COUNT_W=2)
// and a wide instance (WIDTH=8, COUNT_W=8) share clock, reset and controls.
module tb_and_gate_sync;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr;

    logic       a1, b1, y1, yq1, allSeen1;
    logic [3:0] seen1;
    logic [1:0] cnt1;

    logic [7:0] aW, bW, yW, yqW, cntW;
    logic [3:0] seenW;
    logic       allSeenW;

    int checks;
    int errors;

    // Reference model: what each instance should hold after the last edge.
    int         expYq1;
    logic [7:0] expYqW;
    logic [3:0] expSeen1;
    logic [3:0] expSeenW;
    int         expCnt1;
    int         expCntW;

    typedef struct {
        logic       a;
        logic       b;
        logic       y;
        logic [3:0] seenAfter;
    } vec_t;

    vec_t tt[4];

    and_gate_sync #(.WIDTH(1), .COUNT_W(2)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .A(a1), .B(b1), .Y(y1), .Y_q(yq1),
        .seen(seen1), .all_seen(allSeen1), .hi_cnt(cnt1)
    );

    and_gate_sync #(.WIDTH(8), .COUNT_W(8)) dutW (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .A(aW), .B(bW), .Y(yW), .Y_q(yqW),
        .seen(seenW), .all_seen(allSeenW), .hi_cnt(cntW)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        expYq1   = 0;
        expYqW   = 8'h00;
        expSeen1 = 4'b0000;
        expSeenW = 4'b0000;
        expCnt1  = 0;
        expCntW  = 0;
    endtask

    // Advance the model with the inputs that the coming edge will sample,
    // then step past that edge so outputs are settled when checked.
    task automatic applyStimulus();
        int p1;
        int pW;
        p1 = int'(a1) * int'(b1);
        pW = int'(aW & bW);
        if (clr) begin
            expSeen1 = 4'b0000;
            expSeenW = 4'b0000;
            expCnt1  = 0;
            expCntW  = 0;
        end else begin
            expSeen1[int'(a1) * 2 + int'(b1)] = 1'b1;
            expSeenW[int'(aW[0]) * 2 + int'(bW[0])] = 1'b1;
            if (en && p1 != 0) expCnt1 = (expCnt1 + 1 > 3)   ? 3   : expCnt1 + 1;
            if (en && pW != 0) expCntW = (expCntW + 1 > 255) ? 255 : expCntW + 1;
        end
        if (en) begin
            expYq1 = p1;
            expYqW = 8'(pW);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, " Y1"},        32'(y1),       32'(a1 & b1));
        checkOutput({tag, " Yq1"},       32'(yq1),      32'(expYq1));
        checkOutput({tag, " seen1"},     32'(seen1),    32'(expSeen1));
        checkOutput({tag, " allSeen1"},  32'(allSeen1), 32'(expSeen1 == 4'hF));
        checkOutput({tag, " cnt1"},      32'(cnt1),     32'(expCnt1));
        checkOutput({tag, " YW"},        32'(yW),       32'(aW & bW));
        checkOutput({tag, " YqW"},       32'(yqW),      32'(expYqW));
        checkOutput({tag, " seenW"},     32'(seenW),    32'(expSeenW));
        checkOutput({tag, " allSeenW"},  32'(allSeenW), 32'(expSeenW == 4'hF));
        checkOutput({tag, " cntW"},      32'(cntW),     32'(expCntW));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tt[0] = '{a: 1'b0, b: 1'b0, y: 1'b0, seenAfter: 4'b0001};
        tt[1] = '{a: 1'b0, b: 1'b1, y: 1'b0, seenAfter: 4'b0011};
        tt[2] = '{a: 1'b1, b: 1'b0, y: 1'b0, seenAfter: 4'b0111};
        tt[3] = '{a: 1'b1, b: 1'b1, y: 1'b1, seenAfter: 4'b1111};

        rst = 1'b1; en = 1'b0; clr = 1'b0;
        a1 = 1'b0; b1 = 1'b0; aW = 8'h00; bW = 8'h00;
        modelReset();
        #3;
        checkOutput("reset Yq1",      32'(yq1),      32'd0);
        checkOutput("reset seen1",    32'(seen1),    32'd0);
        checkOutput("reset allSeen1", 32'(allSeen1), 32'd0);
        checkOutput("reset cnt1",     32'(cnt1),     32'd0);
        checkOutput("reset cntW",     32'(cntW),     32'd0);
        a1 = 1'b1; b1 = 1'b1;
        #1;
        checkOutput("Y during reset", 32'(y1), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("Yq1 held in reset", 32'(yq1), 32'd0);
        a1 = 1'b0; b1 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Truth table and coverage build-up, each vector held for two edges.
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a1 = tt[i].a;
            b1 = tt[i].b;
            #1;
            checkOutput($sformatf("tt%0d Y", i), 32'(y1), 32'(tt[i].y));
            applyStimulus();
            checkOutput($sformatf("tt%0d Yq", i), 32'(yq1), 32'(tt[i].y));
            applyStimulus();
            checkOutput($sformatf("tt%0d seen", i), 32'(seen1), 32'(tt[i].seenAfter));
            checkOutput($sformatf("tt%0d allSeen", i), 32'(allSeen1), 32'(tt[i].seenAfter == 4'hF));
            checkAll($sformatf("tt%0d", i));
        end

        // Saturation on the 2-bit counter.
        clr = 1'b1;
        applyStimulus();
        checkOutput("clr cnt1", 32'(cnt1), 32'd0);
        clr = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("sat edge%0d cnt1", i + 1), 32'(cnt1), 32'((i + 1 > 3) ? 3 : i + 1));
        end
        en = 1'b0;
        a1 = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("en0 cnt1 holds", 32'(cnt1), 32'd3);
        checkOutput("en0 Yq1 holds",  32'(yq1),  32'd1);
        checkAll("en0");

        // clr beats increment while Y_q still captures.
        en = 1'b1; a1 = 1'b1; b1 = 1'b1;
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("pre-clr cnt1", 32'(cnt1), 32'd2);
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
        checkOutput("clr prio cnt1",  32'(cnt1),  32'd0);
        checkOutput("clr prio seen1", 32'(seen1), 32'd0);
        checkOutput("clr prio Yq1",   32'(yq1),   32'd1);
        checkAll("clr prio");

        // Build up a busy state, then reset between edges.
        for (int i = 0; i < 6; i++) begin
            a1 = (i >= 2) ? 1'b1 : 1'b0;
            b1 = (i == 1 || i >= 3) ? 1'b1 : 1'b0;
            applyStimulus();
        end
        checkOutput("busy Yq1",      32'(yq1),      32'd1);
        checkOutput("busy cnt1",     32'(cnt1),     32'd3);
        checkOutput("busy allSeen1", 32'(allSeen1), 32'd1);
        #3;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async rst Yq1",      32'(yq1),      32'd0);
        checkOutput("async rst cnt1",     32'(cnt1),     32'd0);
        checkOutput("async rst allSeen1", 32'(allSeen1), 32'd0);
        checkOutput("async rst Y1",       32'(y1),       32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Wide operands.
        aW = 8'hF0; bW = 8'h3C;
        #1;
        checkOutput("wide Y", 32'(yW), 32'h30);
        applyStimulus();
        checkOutput("wide Yq",  32'(yqW),  32'h30);
        checkOutput("wide cnt", 32'(cntW), 32'd1);
        checkAll("wide");

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            en  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            aW  = 8'($urandom);
            bW  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            applyStimulus();
            checkAll($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
